// File: rtl/channel_carrier_ctrl.sv
// rtl/channel_carrier_ctrl.sv - carrier NCO with sin/cos table addressing and I/Q epoch integrate-and-dump
module channel_carrier_ctrl #(
    parameter int NCO_W   = 32,
    parameter int ACC_W   = 24,
    parameter int EPOCH_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [1:0]         adc,
    input  logic               adc_valid,
    input  logic [NCO_W-1:0]   freq_word,
    input  logic [NCO_W-1:0]   phase_init,
    input  logic               phase_load,
    input  logic [EPOCH_W-1:0] epoch_len,
    output logic [4:0]         sin_phase_addr,
    output logic [4:0]         cos_phase_addr,
    input  logic [4:0]         sin_product,
    input  logic [4:0]         cos_product,
    output logic [ACC_W-1:0]   dump_i,
    output logic [ACC_W-1:0]   dump_q,
    output logic               dump_valid,
    input  logic               dump_ready,
    output logic               overrun,
    output logic               busy
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             r_state, w_state_nxt;
    logic [NCO_W-1:0]   r_phase;
    logic [ACC_W-1:0]   r_acc_i, r_acc_q, r_dump_i, r_dump_q;
    logic [EPOCH_W-1:0] r_count, r_len;
    logic               r_dump_valid, r_overrun;

    logic               w_accept, w_last, w_dump, w_busy;
    logic [EPOCH_W-1:0] w_len_eff, w_len_cur;
    logic [ACC_W-1:0]   w_sum_i, w_sum_q;
    logic               w_unused;

    // The ADC code goes straight to the external tables; it is not used here.
    assign w_unused = &{1'b0, adc};

    assign sin_phase_addr = r_phase[NCO_W-1 -: 5];
    assign cos_phase_addr = sin_phase_addr + 5'd8;

    assign w_accept  = (r_state == RUN) && adc_valid;
    assign w_len_eff = (epoch_len == '0) ? EPOCH_W'(1) : epoch_len;
    // Epoch length is only taken from the port at the start of an epoch.
    assign w_len_cur = (r_count == '0) ? w_len_eff : r_len;
    assign w_last    = (r_count == (w_len_cur - EPOCH_W'(1)));
    assign w_dump    = w_accept && w_last;

    assign w_sum_i = r_acc_i + {{(ACC_W-5){cos_product[4]}}, cos_product};
    assign w_sum_q = r_acc_q + {{(ACC_W-5){sin_product[4]}}, sin_product};

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        case (r_state)
            IDLE: if (enable) w_state_nxt = RUN;
            RUN: begin
                w_busy = 1'b1;
                if (!enable) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase      <= '0;
            r_acc_i      <= '0;
            r_acc_q      <= '0;
            r_count      <= '0;
            r_len        <= '0;
            r_dump_i     <= '0;
            r_dump_q     <= '0;
            r_dump_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            // A load wins over the increment; the sample that cycle still uses the old phase.
            if (phase_load)    r_phase <= phase_init;
            else if (w_accept) r_phase <= r_phase + freq_word;

            if (r_count == '0) r_len <= w_len_eff;

            if (r_state != RUN) begin
                r_acc_i <= '0;
                r_acc_q <= '0;
                r_count <= '0;
            end else if (w_accept) begin
                if (w_last) begin
                    r_dump_i <= w_sum_i;
                    r_dump_q <= w_sum_q;
                    r_acc_i  <= '0;
                    r_acc_q  <= '0;
                    r_count  <= '0;
                end else begin
                    r_acc_i <= w_sum_i;
                    r_acc_q <= w_sum_q;
                    r_count <= r_count + EPOCH_W'(1);
                end
            end

            if (w_dump)          r_dump_valid <= 1'b1;
            else if (dump_ready) r_dump_valid <= 1'b0;

            if (w_dump && r_dump_valid && !dump_ready) r_overrun <= 1'b1;
        end
    end

    assign dump_i     = r_dump_i;
    assign dump_q     = r_dump_q;
    assign dump_valid = r_dump_valid;
    assign overrun    = r_overrun;
    assign busy       = w_busy;

endmodule

// File: tb/tb_channel_carrier_ctrl.sv
// tb/tb_channel_carrier_ctrl.sv - directed self-checking bench for channel_carrier_ctrl
module tb_channel_carrier_ctrl;

    logic        clk = 1'b0;
    logic        reset, enable, adc_valid, phase_load, dump_ready;
    logic [1:0]  adc;
    logic [31:0] freq_word, phase_init;
    logic [15:0] epoch_len;
    logic [4:0]  sin_phase_addr, cos_phase_addr, sin_product, cos_product;
    logic [23:0] dump_i, dump_q;
    logic        dump_valid, overrun, busy;

    int npass  = 0;
    int ntotal = 0;

    always #5 clk = ~clk;

    channel_carrier_ctrl dut (
        .clk(clk), .reset(reset), .enable(enable), .adc(adc), .adc_valid(adc_valid),
        .freq_word(freq_word), .phase_init(phase_init), .phase_load(phase_load),
        .epoch_len(epoch_len), .sin_phase_addr(sin_phase_addr), .cos_phase_addr(cos_phase_addr),
        .sin_product(sin_product), .cos_product(cos_product), .dump_i(dump_i), .dump_q(dump_q),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .overrun(overrun), .busy(busy)
    );

    // 32-entry sine table, peak 9, scaled by the ADC code (01:+1, 11:-1, else 0).
    function automatic int quarter(input int k);
        case (k)
            0: return 0; 1: return 2; 2: return 3; 3: return 5; 4: return 6;
            5: return 7; 6: return 8; 7: return 9; default: return 9;
        endcase
    endfunction

    function automatic logic [4:0] tab(input logic [4:0] a, input logic [1:0] code);
        int k, v;
        k = int'(a) % 16;
        v = quarter((k <= 8) ? k : 16 - k);
        if (a >= 5'd16) v = -v;
        if (code == 2'b11)      v = -v;
        else if (code != 2'b01) v = 0;
        return 5'(v);
    endfunction

    assign sin_product = tab(sin_phase_addr, adc);
    assign cos_product = tab(cos_phase_addr, adc);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        adc_valid = 1'b1;
        tick();
        adc_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic start(input logic [31:0] fw, input logic [15:0] len);
        enable = 1'b0; do_reset();
        freq_word = fw; epoch_len = len; adc = 2'b01;
        enable = 1'b1; tick();
    endtask

    task automatic test_reset();
        do_reset();
        ntotal++; if (dump_valid !== 1'b0) $display("FAIL reset_valid got %0b exp 0", dump_valid); else npass++;
        ntotal++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b exp 0", busy); else npass++;
        ntotal++; if (cos_phase_addr !== 5'd8) $display("FAIL reset_cos got %0d exp 8", cos_phase_addr); else npass++;
    endtask

    task automatic test_dc();
        start(32'h0, 16'd4);
        ntotal++; if (busy !== 1'b1) $display("FAIL dc_busy got %0b exp 1", busy); else npass++;
        repeat (3) sample();
        ntotal++; if (dump_valid !== 1'b0) $display("FAIL dc_early got %0b exp 0", dump_valid); else npass++;
        sample();
        ntotal++; if (dump_valid !== 1'b1) $display("FAIL dc_valid got %0b exp 1", dump_valid); else npass++;
        ntotal++; if (dump_i !== 24'd36) $display("FAIL dc_i got %0h exp 24", dump_i); else npass++;
        ntotal++; if (dump_q !== 24'd0) $display("FAIL dc_q got %0h exp 0", dump_q); else npass++;
        dump_ready = 1'b1; tick(); dump_ready = 1'b0;
        ntotal++; if (dump_valid !== 1'b0) $display("FAIL dc_read got %0b exp 0", dump_valid); else npass++;
    endtask

    task automatic test_rotation();
        start(32'h0800_0000, 16'd32);
        for (int k = 0; k < 32; k++) begin
            ntotal++; if (sin_phase_addr !== 5'(k)) $display("FAIL rot_sin got %0d exp %0d", sin_phase_addr, k); else npass++;
            ntotal++; if (cos_phase_addr !== 5'(k + 8)) $display("FAIL rot_cos got %0d exp %0d", cos_phase_addr, (k + 8) % 32); else npass++;
            sample();
        end
        ntotal++; if (dump_valid !== 1'b1) $display("FAIL rot_valid got %0b exp 1", dump_valid); else npass++;
        ntotal++; if (dump_i !== 24'd0) $display("FAIL rot_i got %0h exp 0", dump_i); else npass++;
        ntotal++; if (dump_q !== 24'd0) $display("FAIL rot_q got %0h exp 0", dump_q); else npass++;
    endtask

    task automatic test_backpressure();
        start(32'h0, 16'd4);
        repeat (4) sample();
        ntotal++; if (overrun !== 1'b0) $display("FAIL bp_first_ovr got %0b exp 0", overrun); else npass++;
        repeat (4) sample();
        ntotal++; if (overrun !== 1'b1) $display("FAIL bp_ovr got %0b exp 1", overrun); else npass++;
        ntotal++; if (dump_i !== 24'd36) $display("FAIL bp_i got %0h exp 24", dump_i); else npass++;
        tick();
        ntotal++; if (overrun !== 1'b1) $display("FAIL bp_sticky got %0b exp 1", overrun); else npass++;
    endtask

    task automatic test_reset_mid_epoch();
        freq_word = 32'h0800_0000;
        sample();
        ntotal++; if (sin_phase_addr !== 5'd1) $display("FAIL rm_pre got %0d exp 1", sin_phase_addr); else npass++;
        enable = 1'b0; do_reset();
        ntotal++; if (dump_valid !== 1'b0) $display("FAIL rm_valid got %0b exp 0", dump_valid); else npass++;
        ntotal++; if (overrun !== 1'b0) $display("FAIL rm_ovr got %0b exp 0", overrun); else npass++;
        ntotal++; if (dump_i !== 24'd0) $display("FAIL rm_i got %0h exp 0", dump_i); else npass++;
        ntotal++; if (busy !== 1'b0) $display("FAIL rm_busy got %0b exp 0", busy); else npass++;
        ntotal++; if (sin_phase_addr !== 5'd0) $display("FAIL rm_sin got %0d exp 0", sin_phase_addr); else npass++;
        ntotal++; if (cos_phase_addr !== 5'd8) $display("FAIL rm_cos got %0d exp 8", cos_phase_addr); else npass++;
    endtask

    task automatic test_ready_on_dump();
        start(32'h0, 16'd4);
        repeat (4) sample();
        adc = 2'b11;
        repeat (3) sample();
        dump_ready = 1'b1; sample();
        ntotal++; if (dump_valid !== 1'b1) $display("FAIL rd_valid got %0b exp 1", dump_valid); else npass++;
        ntotal++; if (overrun !== 1'b0) $display("FAIL rd_ovr got %0b exp 0", overrun); else npass++;
        ntotal++; if (dump_i !== 24'hFFFFDC) $display("FAIL rd_i got %0h exp ffffdc", dump_i); else npass++;
        tick(); dump_ready = 1'b0;
        ntotal++; if (dump_valid !== 1'b0) $display("FAIL rd_clear got %0b exp 0", dump_valid); else npass++;
    endtask

    task automatic test_phase_load();
        start(32'h0800_0000, 16'd2);
        phase_init = 32'h4000_0000; phase_load = 1'b1; adc_valid = 1'b1;
        #1;
        ntotal++; if (sin_phase_addr !== 5'd0) $display("FAIL pl_first got %0d exp 0", sin_phase_addr); else npass++;
        tick();
        phase_load = 1'b0; adc_valid = 1'b0;
        ntotal++; if (sin_phase_addr !== 5'd8) $display("FAIL pl_next got %0d exp 8", sin_phase_addr); else npass++;
        sample();
        ntotal++; if (dump_valid !== 1'b1) $display("FAIL pl_valid got %0b exp 1", dump_valid); else npass++;
        ntotal++; if (dump_i !== 24'd9) $display("FAIL pl_i got %0h exp 9", dump_i); else npass++;
        ntotal++; if (dump_q !== 24'd9) $display("FAIL pl_q got %0h exp 9", dump_q); else npass++;
        ntotal++; if (sin_phase_addr !== 5'd9) $display("FAIL pl_after got %0d exp 9", sin_phase_addr); else npass++;
    endtask

    task automatic test_enable_drop();
        start(32'h0, 16'd4);
        dump_ready = 1'b1;
        repeat (2) sample();
        enable = 1'b0; tick();
        ntotal++; if (busy !== 1'b0) $display("FAIL ed_busy got %0b exp 0", busy); else npass++;
        ntotal++; if (dump_valid !== 1'b0) $display("FAIL ed_nodump got %0b exp 0", dump_valid); else npass++;
        repeat (2) sample();
        enable = 1'b1; tick();
        repeat (3) sample();
        ntotal++; if (dump_valid !== 1'b0) $display("FAIL ed_early got %0b exp 0", dump_valid); else npass++;
        sample();
        ntotal++; if (dump_valid !== 1'b1) $display("FAIL ed_valid got %0b exp 1", dump_valid); else npass++;
        ntotal++; if (dump_i !== 24'd36) $display("FAIL ed_i got %0h exp 24", dump_i); else npass++;
        dump_ready = 1'b0;
    endtask

    task automatic test_epoch_len();
        start(32'h0, 16'd0);
        dump_ready = 1'b1;
        sample();
        ntotal++; if (dump_valid !== 1'b1) $display("FAIL el_zero_valid got %0b exp 1", dump_valid); else npass++;
        ntotal++; if (dump_i !== 24'd9) $display("FAIL el_zero_i got %0h exp 9", dump_i); else npass++;
        epoch_len = 16'd4; sample();
        epoch_len = 16'd2; sample();
        ntotal++; if (dump_valid !== 1'b0) $display("FAIL el_latched got %0b exp 0", dump_valid); else npass++;
        repeat (2) sample();
        ntotal++; if (dump_valid !== 1'b1) $display("FAIL el_valid got %0b exp 1", dump_valid); else npass++;
        ntotal++; if (dump_i !== 24'd36) $display("FAIL el_i got %0h exp 24", dump_i); else npass++;
        dump_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; adc = 2'b01; adc_valid = 1'b0;
        freq_word = '0; phase_init = '0; phase_load = 1'b0;
        epoch_len = 16'd4; dump_ready = 1'b0;
        test_reset();
        test_dc();
        test_rotation();
        test_backpressure();
        test_reset_mid_epoch();
        test_ready_on_dump();
        test_phase_load();
        test_enable_drop();
        test_epoch_len();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
